gravity_div_responder: RTL and testbench

- Responder end of the centroid-sum handshake in the eye-tracker pipeline.
- Captures S, SX and SY when the gravity calculator raises its start trigger, then asserts BUSY.
- Runs two parallel serial restoring divisions (SX/S, SY/S) with fixed-point fraction bits, then drops BUSY and presents the centroid with a one-cycle VALID.
- Its BUSY rising and falling edges are what the upstream calculator waits on before returning to idle.

---
 rtl/gravity_div_pkg.sv | 22 ++
 rtl/gravity_div_unit.sv | 66 ++++++
 rtl/gravity_div_responder.sv | 149 ++++++++++++++
 tb/tb_gravity_div_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/gravity_div_pkg.sv
// Shared widths, state encoding and divider step count for the centroid-sum
// handshake between the gravity calculator and the divider responder.
package gravity_div_pkg;

    localparam int SUM_S_WIDTH  = 20;
    localparam int SUM_SX_WIDTH = 28;
    localparam int SUM_SY_WIDTH = 28;

    // Step counter width; the upstream calculator gives up after 4095 cycles.
    localparam int CNT_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int div_steps(input int sx_w, input int sy_w, input int frac_bits);
        return ((sx_w > sy_w) ? sx_w : sy_w) + frac_bits;
    endfunction

endpackage

// File: rtl/gravity_div_unit.sv
// Serial restoring divider: one quotient bit per step, MSB first.
// quot_o already includes the bit produced by the current step.
module gravity_div_unit #(
    parameter int DVD_W = 32,
    parameter int DVS_W = 20
) (
    input  logic             CCLK,
    input  logic             RST_N,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [DVD_W-1:0] quot_o,
    output logic [DVS_W:0]   rem_o
);

    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [DVS_W:0]   rem_q, rem_d;
    logic [DVS_W:0]   rem_shift;
    logic [DVD_W-1:0] quo_step;
    logic             fits;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        // The remainder stays below the divisor, so its top bit is free to shift out.
        rem_shift = {rem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
        fits      = (rem_shift >= {1'b0, dvs_q});
        quo_step  = {quo_q[DVD_W-2:0], fits};

        if (load_i) begin
            dvd_d = dividend_i;
            dvs_d = divisor_i;
            rem_d = '0;
            quo_d = '0;
        end else if (step_i) begin
            dvd_d = dvd_q << 1;
            rem_d = fits ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
            quo_d = quo_step;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            dvd_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
        end else begin
            dvd_q <= dvd_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
        end
    end

    assign quot_o = quo_step;
    assign rem_o  = rem_q;

endmodule

// File: rtl/gravity_div_responder.sv
// Responder end of the centroid-sum handshake: on a start rising edge it divides
// SX/S and SY/S in fixed point, holding BUSY for a fixed DIV_STEPS cycles.
module gravity_div_responder
    import gravity_div_pkg::*;
#(
    parameter int ADDR_WIDTH   = 11,
    parameter int FRAC_BITS    = 4,
    parameter int SUM_S_WIDTH  = gravity_div_pkg::SUM_S_WIDTH,
    parameter int SUM_SX_WIDTH = gravity_div_pkg::SUM_SX_WIDTH,
    parameter int SUM_SY_WIDTH = gravity_div_pkg::SUM_SY_WIDTH
) (
    input  logic                            CCLK,
    input  logic                            RST_N,
    input  logic                            iSTART_TRIG,
    input  logic [SUM_S_WIDTH-1:0]          iSUM_S,
    input  logic [SUM_SX_WIDTH-1:0]         iSUM_SX,
    input  logic [SUM_SY_WIDTH-1:0]         iSUM_SY,
    output logic                            oBUSY,
    output logic                            oVALID,
    output logic [ADDR_WIDTH+FRAC_BITS-1:0] oGRAV_X,
    output logic [ADDR_WIDTH+FRAC_BITS-1:0] oGRAV_Y,
    output logic                            oDIV_ZERO,
    output logic                            oSAT,
    output logic [1:0]                      oSTATE
);

    localparam int DIV_STEPS = div_steps(SUM_SX_WIDTH, SUM_SY_WIDTH, FRAC_BITS);
    localparam int OUT_W     = ADDR_WIDTH + FRAC_BITS;

    state_e                 state_q, state_d;
    logic                   trig_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   div_zero_q, div_zero_d;
    logic                   sat_q, sat_d;
    logic                   s_zero_q, s_zero_d;
    logic [OUT_W-1:0]       grav_x_q, grav_x_d;
    logic [OUT_W-1:0]       grav_y_q, grav_y_d;
    logic                   rise, div_load, div_step, x_sat, y_sat;
    logic [DIV_STEPS-1:0]   quot_x, quot_y;
    logic [SUM_S_WIDTH:0]   rem_x, rem_y;
    logic                   unused_rem;

    gravity_div_unit #(.DVD_W(DIV_STEPS), .DVS_W(SUM_S_WIDTH)) u_div_x (
        .CCLK       (CCLK),
        .RST_N      (RST_N),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (DIV_STEPS'({iSUM_SX, FRAC_BITS'(0)})),
        .divisor_i  (iSUM_S),
        .quot_o     (quot_x),
        .rem_o      (rem_x)
    );

    gravity_div_unit #(.DVD_W(DIV_STEPS), .DVS_W(SUM_S_WIDTH)) u_div_y (
        .CCLK       (CCLK),
        .RST_N      (RST_N),
        .load_i     (div_load),
        .step_i     (div_step),
        .dividend_i (DIV_STEPS'({iSUM_SY, FRAC_BITS'(0)})),
        .divisor_i  (iSUM_S),
        .quot_o     (quot_y),
        .rem_o      (rem_y)
    );

    assign unused_rem = ^{rem_x, rem_y};
    assign rise       = iSTART_TRIG & ~trig_q;
    assign x_sat      = |quot_x[DIV_STEPS-1:OUT_W];
    assign y_sat      = |quot_y[DIV_STEPS-1:OUT_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        div_zero_d = div_zero_q;
        sat_d      = sat_q;
        s_zero_d   = s_zero_q;
        grav_x_d   = grav_x_q;
        grav_y_d   = grav_y_q;
        div_load   = 1'b0;
        div_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    div_load = 1'b1;
                    s_zero_d = (iSUM_S == '0);
                    cnt_d    = CNT_WIDTH'(DIV_STEPS - 1);
                    busy_d   = 1'b1;
                    state_d  = ST_DIV;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt_q == '0) begin
                    // Results are taken from the final step's quotient so VALID lines up with BUSY falling.
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    valid_d    = 1'b1;
                    div_zero_d = s_zero_q;
                    sat_d      = ~s_zero_q & (x_sat | y_sat);
                    grav_x_d   = s_zero_q ? '0 : (x_sat ? '1 : quot_x[OUT_W-1:0]);
                    grav_y_d   = s_zero_q ? '0 : (y_sat ? '1 : quot_y[OUT_W-1:0]);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            trig_q     <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            div_zero_q <= 1'b0;
            sat_q      <= 1'b0;
            s_zero_q   <= 1'b0;
            grav_x_q   <= '0;
            grav_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= iSTART_TRIG;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            div_zero_q <= div_zero_d;
            sat_q      <= sat_d;
            s_zero_q   <= s_zero_d;
            grav_x_q   <= grav_x_d;
            grav_y_q   <= grav_y_d;
        end
    end

    assign oBUSY     = busy_q;
    assign oVALID    = valid_q;
    assign oGRAV_X   = grav_x_q;
    assign oGRAV_Y   = grav_y_q;
    assign oDIV_ZERO = div_zero_q;
    assign oSAT      = sat_q;
    assign oSTATE    = state_q;

endmodule

// File: tb/tb_gravity_div_responder.sv
// Self-checking bench for gravity_div_responder: directed and random divisions
// compared against an arithmetic centroid model, plus handshake and reset cases.
module tb_gravity_div_responder;

    localparam int ADDR_W = 11;
    localparam int FRAC   = 4;
    localparam int OUT_W  = ADDR_W + FRAC;
    localparam int STEPS  = 32;
    localparam longint OUT_MAX = (64'd1 << OUT_W) - 1;

    logic        CCLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        trig = 1'b0;
    logic [19:0] s_in = '0;
    logic [27:0] sx_in = '0;
    logic [27:0] sy_in = '0;

    logic              busy, valid, div_zero, sat;
    logic [OUT_W-1:0]  gx, gy;
    logic [1:0]        state;

    int tests = 0;
    int fails = 0;

    gravity_div_responder dut (
        .CCLK        (CCLK),
        .RST_N       (RST_N),
        .iSTART_TRIG (trig),
        .iSUM_S      (s_in),
        .iSUM_SX     (sx_in),
        .iSUM_SY     (sy_in),
        .oBUSY       (busy),
        .oVALID      (valid),
        .oGRAV_X     (gx),
        .oGRAV_Y     (gy),
        .oDIV_ZERO   (div_zero),
        .oSAT        (sat),
        .oSTATE      (state)
    );

    always #5 CCLK = ~CCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    // Centroid = floor(sum * 2^FRAC / S), clamped to the output width; S==0 reports zero.
    function automatic void model(input longint s, input longint sx, input longint sy,
                                  output longint ex, output longint ey,
                                  output bit dz, output bit st);
        longint qx, qy;
        if (s == 0) begin
            ex = 0; ey = 0; dz = 1'b1; st = 1'b0;
        end else begin
            qx = (sx * (64'd1 << FRAC)) / s;
            qy = (sy * (64'd1 << FRAC)) / s;
            dz = 1'b0;
            st = (qx > OUT_MAX) || (qy > OUT_MAX);
            ex = (qx > OUT_MAX) ? OUT_MAX : qx;
            ey = (qy > OUT_MAX) ? OUT_MAX : qy;
        end
    endfunction

    task automatic run_op(input longint s, input longint sx, input longint sy, input string tag);
        longint ex, ey;
        bit     dz, st;
        int     busy_cnt;
        bit     fell;
        model(s, sx, sy, ex, ey, dz, st);
        s_in  = 20'(s);
        sx_in = 28'(sx);
        sy_in = 28'(sy);
        trig  = 1'b1;
        tick();
        trig  = 1'b0;
        // Sums are only sampled on the rise; scramble them afterwards.
        s_in  = 20'($urandom);
        sx_in = 28'($urandom);
        sy_in = 28'($urandom);
        busy_cnt = 0;
        fell     = 1'b0;
        for (int i = 0; i < 100 && !fell; i++) begin
            if (busy) begin
                busy_cnt++;
                tick();
            end else begin
                fell = 1'b1;
            end
        end
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(STEPS));
        check({tag, " valid_at_fall"}, 64'(valid), 64'd1);
        check({tag, " state_done"}, 64'(state), 64'd2);
        check({tag, " grav_x"}, 64'(gx), ex);
        check({tag, " grav_y"}, 64'(gy), ey);
        check({tag, " div_zero"}, 64'(div_zero), 64'(dz));
        check({tag, " sat"}, 64'(sat), 64'(st));
        tick();
        check({tag, " valid_one_cycle"}, 64'(valid), 64'd0);
        check({tag, " state_idle"}, 64'(state), 64'd0);
    endtask

    initial begin
        int     vcount;
        longint rs, rsx, rsy;

        repeat (3) tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset grav_x", 64'(gx), 64'd0);
        check("reset grav_y", 64'(gy), 64'd0);
        check("reset flags", 64'({div_zero, sat}), 64'd0);
        check("reset state", 64'(state), 64'd0);
        RST_N = 1'b1;
        repeat (2) tick();

        run_op(10, 3200, 2400, "basic");
        run_op(2, 7, 1, "fraction");
        run_op(0, 100, 100, "div_zero");
        run_op(1, 64'h7FF_FFFF, 5, "saturate");

        // Trigger held for 600 cycles with an extra rise injected during the division.
        s_in  = 20'd10;
        sx_in = 28'd3200;
        sy_in = 28'd2400;
        trig  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (valid) vcount++;
            if (i == 10) trig = 1'b0;
            if (i == 11) trig = 1'b1;
        end
        trig = 1'b0;
        tick();
        check("held one_valid", 64'(vcount), 64'd1);
        check("held grav_x", 64'(gx), 64'h1400);
        check("held grav_y", 64'(gy), 64'h0F00);
        run_op(2, 7, 1, "fresh_rise");

        // Reset in the middle of a division aborts it without a VALID.
        s_in  = 20'd3;
        sx_in = 28'd900;
        sy_in = 28'd600;
        trig  = 1'b1;
        tick();
        trig  = 1'b0;
        repeat (10) tick();
        check("abort busy_before", 64'(busy), 64'd1);
        RST_N = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort grav_x", 64'(gx), 64'd0);
        check("abort grav_y", 64'(gy), 64'd0);
        check("abort state", 64'(state), 64'd0);
        check("abort valid", 64'(valid), 64'd0);
        repeat (2) tick();
        RST_N = 1'b1;
        vcount = 0;
        repeat (50) begin
            tick();
            if (valid) vcount++;
        end
        check("abort no_valid", 64'(vcount), 64'd0);
        run_op(10, 3200, 2400, "after_abort");

        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 2) == 0) rs = longint'($urandom_range(0, 15));
            else                           rs = longint'($urandom_range(0, 20'hFFFFF));
            rsx = longint'($urandom & 32'h0FFF_FFFF);
            rsy = longint'($urandom_range(0, 32'h0FFF_FFFF) >> $urandom_range(0, 20));
            run_op(rs, rsx, rsy, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
